// File: rtl/laser_beam_tx_if.sv
// Laser tripwire transmit-side signal bundle.
// The master modport is the transmitter. The slave modport is the enable
// source and the receiver/comparator that consumes the timing outputs.
interface laser_beam_tx_if;
  logic        enable;
  logic        laser_drive;
  logic        expected_level;
  logic        sample_strobe;
  logic        ambient_strobe;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        busy;

  modport master (
    input  enable,
    output laser_drive, expected_level, sample_strobe, ambient_strobe,
           frame_start, frame_count, busy
  );

  modport slave (
    output enable,
    input  laser_drive, expected_level, sample_strobe, ambient_strobe,
           frame_start, frame_count, busy
  );
endinterface

// File: rtl/laser_beam_tx.sv
// Laser tripwire transmitter.
// Each frame has three parts: ambient (laser off), LFSR-keyed code bits,
// and a steady-on gap. A steady light source therefore cannot spoof the beam.
// Every output is a flop. The outputs are decoded from next-state values,
// so each output lines up with the state that is current in the same cycle.
module laser_beam_tx #(
  parameter int          BIT_CYCLES   = 50000,
  parameter int          CODE_BITS    = 16,
  parameter int          AMBIENT_BITS = 2,
  parameter int          GAP_BITS     = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              clock,
  input  logic              rst,
  laser_beam_tx_if.master   bus
);

  localparam int TW    = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int MAXB0 = (CODE_BITS > AMBIENT_BITS) ? CODE_BITS : AMBIENT_BITS;
  localparam int MAXB  = (MAXB0 > GAP_BITS) ? MAXB0 : GAP_BITS;
  localparam int BW    = (MAXB > 1) ? $clog2(MAXB) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MID  = TW'(BIT_CYCLES / 2);
  localparam logic [BW-1:0] AMB_LAST   = BW'(AMBIENT_BITS - 1);
  localparam logic [BW-1:0] CODE_LAST  = BW'(CODE_BITS - 1);
  localparam logic [BW-1:0] GAP_LAST   = BW'(GAP_BITS - 1);
  // An all-zero seed would lock the LFSR at zero.
  localparam logic [15:0]   SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {IDLE, AMBIENT, CODE, GAP} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_idx_q, bit_idx_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          bit_end;

  logic laser_q, laser_d;
  logic level_q, level_d;
  logic samp_q, samp_d;
  logic amb_q, amb_d;
  logic fstart_q, fstart_d;
  logic busy_q, busy_d;

  // State, timing and output registers. Reset overrides every other input.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      bit_idx_q     <= '0;
      lfsr_q        <= SEED;
      frame_count_q <= '0;
      laser_q       <= 1'b0;
      level_q       <= 1'b0;
      samp_q        <= 1'b0;
      amb_q         <= 1'b0;
      fstart_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_idx_q     <= bit_idx_d;
      lfsr_q        <= lfsr_d;
      frame_count_q <= frame_count_d;
      laser_q       <= laser_d;
      level_q       <= level_d;
      samp_q        <= samp_d;
      amb_q         <= amb_d;
      fstart_q      <= fstart_d;
      busy_q        <= busy_d;
    end
  end

  // Next state: the bit timer, the bit index within the current phase,
  // the LFSR step and the completed-frame counter.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    bit_idx_d     = bit_idx_q;
    lfsr_d        = lfsr_q;
    frame_count_d = frame_count_q;
    bit_end       = (timer_q == TIMER_LAST);

    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + 1'b1;
      if (bit_end) bit_idx_d = bit_idx_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_idx_d = '0;
        if (bus.enable) state_d = AMBIENT;
      end
      AMBIENT: begin
        if (bit_end && bit_idx_q == AMB_LAST) begin
          state_d   = CODE;
          bit_idx_d = '0;
        end
      end
      CODE: begin
        // Galois right shift. The LFSR steps once per code bit and is never
        // reseeded between frames.
        if (bit_end)
          lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        if (bit_end && bit_idx_q == CODE_LAST) begin
          state_d   = GAP;
          bit_idx_d = '0;
        end
      end
      GAP: begin
        if (bit_end && bit_idx_q == GAP_LAST) begin
          frame_count_d = frame_count_q + 16'd1;
          bit_idx_d     = '0;
          // Dropping enable only takes effect here, so a frame always completes.
          state_d       = bus.enable ? AMBIENT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from next-state values, so the registered outputs line up
  // with the state held in the same cycle.
  always_comb begin
    laser_d  = 1'b0;
    level_d  = 1'b0;
    samp_d   = 1'b0;
    amb_d    = 1'b0;
    fstart_d = 1'b0;
    busy_d   = (state_d != IDLE);
    case (state_d)
      AMBIENT: begin
        amb_d    = (timer_d == TIMER_MID);
        fstart_d = (state_q != AMBIENT);
      end
      CODE: begin
        laser_d = lfsr_d[0];
        level_d = lfsr_d[0];
        samp_d  = (timer_d == TIMER_MID);
      end
      GAP: begin
        laser_d = 1'b1;
        level_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.laser_drive    = laser_q;
  assign bus.expected_level = level_q;
  assign bus.sample_strobe  = samp_q;
  assign bus.ambient_strobe = amb_q;
  assign bus.frame_start    = fstart_q;
  assign bus.frame_count    = frame_count_q;
  assign bus.busy           = busy_q;

endmodule
